// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Latency: accept to rsp_valid 1 cycle; response held (backpressure) until owner's rsp_ready, no accept meanwhile.
module alu_arbiter #(
  parameter int FIRST_PRIO = 0,
  parameter int WORD_W     = 32,
  parameter int OP_W       = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WORD_W-1:0] req0_portA,
  input  logic [WORD_W-1:0] req1_portA,
  input  logic [WORD_W-1:0] req0_portB,
  input  logic [WORD_W-1:0] req1_portB,
  input  logic [OP_W-1:0]   req0_aluop,
  input  logic [OP_W-1:0]   req1_aluop,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WORD_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [WORD_W-1:0] alu_portA,
  output logic [WORD_W-1:0] alu_portB,
  output logic [OP_W-1:0]   alu_aluop,
  input  logic [WORD_W-1:0] alu_output_port,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state;
  logic   prio;
  logic   owner;
  logic   grant;
  logic   winner;

  always_comb begin
    grant     = (state == IDLE) && (req_valid != 2'b00);
    // a lone requester wins outright; prio only breaks ties
    winner    = (req_valid == 2'b11) ? prio : req_valid[1];
    req_ready = 2'b00;
    alu_portA = '0;
    alu_portB = '0;
    alu_aluop = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
      if (winner) begin
        alu_portA = req1_portA;
        alu_portB = req1_portB;
        alu_aluop = req1_aluop;
      end else begin
        alu_portA = req0_portA;
        alu_portB = req0_portB;
        alu_aluop = req0_aluop;
      end
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign busy = (state == RESP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      prio       <= (FIRST_PRIO != 0);
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            rsp_result <= alu_output_port;
            rsp_flags  <= {alu_negative, alu_overflow, alu_zero};
            owner      <= winner;
            prio       <= ~winner;
            state      <= RESP;
          end
        end
        RESP: begin
          // the other requester's rsp_ready is deliberately ignored
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. requester 0 = execute stage and requester 1 = a multi-cycle helper unit such as a mult/div sequencer.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; each ALU result and its flags are registered and held until the owning requester accepts them.
- Sits between the requesters and the ALU ports: portA, portB, aluop out; output_port, negative, overflow, zero in.

Parameters:
- FIRST_PRIO, default 0: requester that wins a simultaneous request first after reset (0 or 1).
- WORD_W, default 32: data width, equal to word_t.
- OP_W, default 4: ALU op width, equal to aluop_t.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation accepted this cycle.
- req0_portA, req1_portA  in  WORD_W each  operand A per requester.
- req0_portB, req1_portB  in  WORD_W each  operand B per requester.
- req0_aluop, req1_aluop  in  OP_W each  ALU op per requester.
- rsp_valid  out  2  bit i: response for requester i available.
- rsp_ready  in  2  bit i: requester i takes its response.
- rsp_result  out  WORD_W  registered output_port (shared bus, qualified by rsp_valid).
- rsp_flags  out  3  registered {negative, overflow, zero}.
- alu_portA, alu_portB  out  WORD_W  to ALU.
- alu_aluop  out  OP_W  to ALU.
- alu_output_port  in  WORD_W  from ALU.
- alu_negative, alu_overflow, alu_zero  in  1 each  from ALU.
- busy  out  1  high while state is RESP.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, prio=FIRST_PRIO, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0.
- States: IDLE, RESP. Register owner (1 bit) records which requester is being served.
- IDLE, no valid: alu_* outputs driven to 0; req_ready=0.
- IDLE, only req_valid[i]: winner=i.
- IDLE, both valid: winner=prio.
- IDLE, grant actions:
  - alu_* driven combinationally from the winner's operands.
  - req_ready[winner]=1 the same cycle; req_ready is combinational from req_valid and state.
  - At the clock edge: rsp_result<=alu_output_port; rsp_flags<={alu_negative,alu_overflow,alu_zero}; owner<=winner; prio<=~winner; state<=RESP.
- Request rule: a requester holds valid and operands stable until it sees ready. The arbiter never asserts ready to a requester whose valid is low.
- RESP:
  - rsp_valid[owner]=1; rsp_valid[~owner]=0.
  - req_ready=0 for both requesters; alu_* driven to 0.
  - rsp_result and rsp_flags held stable.
  - When rsp_ready[owner]=1: state<=IDLE at that edge.
  - Otherwise stay in RESP indefinitely (backpressure).
  - rsp_ready[~owner] is ignored.
- Latency and throughput: request accept to rsp_valid = 1 cycle. Maximum throughput is 1 op per 2 cycles; no overlap of response and next accept.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1... (FIRST_PRIO=0). Worst-case wait is one other operation plus its response stall.
- Width rules: data is passed through unmodified. The arbiter never interprets aluop or flags; overflow semantics are the ALU's.
- RST asserted mid-operation (any state): pending response discarded; all registers return to reset values at that edge; req_ready and rsp_valid are low in the cycle after the edge.
- Simultaneous events:
  - A new req_valid during RESP is not accepted until after return to IDLE.
  - rsp_ready together with req_valid in the same RESP cycle: only the response completes; the request is accepted in the following IDLE cycle.

Test Plan:
- Reset then single request: req0 valid, A=5, B=7, op=ALU_ADD -> req_ready=2'b01 same cycle; next cycle rsp_valid=2'b01, rsp_result=12, flags=000; rsp_ready[0]=1 -> IDLE next cycle.
- Simultaneous requests, FIRST_PRIO=0, rsp_ready tied high:
  - req0 A=3, B=3, op=ALU_SUB; req1 A=0x80000000, B=1, op=ALU_SUB.
  - Required: req0 granted first with result 0, flags 001.
  - Then req1 granted with result 0x7FFFFFFF and overflow=1.
  - Then prio=0 again.
- Backpressure: grant req1, hold rsp_ready=0 for 5 cycles while req0 valid -> rsp_valid[1] and rsp_result stable, req_ready=0 throughout, busy=1; release -> req0 granted the next cycle.
- Continuous contention: 8 cycles with both valid and rsp_ready=2'b11 -> grant sequence 0,1,0,1 with one grant every 2 cycles; each result matches its owner's operands.
- Reset mid-RESP: RST high while rsp_valid=2'b10 -> the cycle after the edge rsp_valid=0, busy=0, rsp_result=0; a post-reset simultaneous request is granted to FIRST_PRIO.
- Wrong-owner ready: in RESP with owner=0, assert only rsp_ready[1] -> state stays RESP and rsp_valid remains 2'b01.
